imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Decode-stage register slice that sits directly upstream of SignExtender in the LEGv8 datapath.
- Captures a fetched 32-bit instruction and its PC, classifies the instruction format, and extracts the immediate field.
- Widens the field to 64 bits through SignExtender instances or zero-extension, then presents the result to execute/branch logic behind a valid/ready handshake.

Parameters:
- DATA_W, 64, width of PC and extended immediate.
- INSTR_W, 32, instruction width; fixed by the ISA, not overridable in practice.
- BR_SHIFT, 2, left shift applied to B/CB word offsets.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_W  instruction PC.
- flush  in  1  kill the held instruction (branch redirect).
- out_valid  out  1  output holds a decoded instruction.
- out_ready  in  1  downstream accepts.
- out_pc  out  DATA_W  registered PC.
- out_imm  out  DATA_W  extended immediate.
- out_fmt  out  3  format code: R=0, I=1, D=2, B=3, CB=4, IW=5.
- out_illegal  out  1  opcode unmatched.

Behaviour:
- Reset: out_valid=0, out_pc=0, out_imm=0, out_fmt=R, out_illegal=0. Reset beats flush and load.
- in_ready = !out_valid || out_ready. This is combinational; no skid buffer.
- Load: when in_valid && in_ready && !flush, all out_* register the decode of in_instr on the next edge, and out_valid becomes 1. Latency is 1 cycle, and throughput is 1 per cycle when out_ready is held high.
- Hold: when out_valid && !out_ready, all outputs are frozen.
- Drain: when out_ready && !(in_valid && in_ready), out_valid clears to 0 on the next edge and the data outputs keep their values.
- Flush:
  - out_valid goes to 0 on the next edge, regardless of in_valid, out_ready or stall.
  - Data outputs do not change.
  - An input presented in the same cycle is dropped.
- Opcode match is first-hit in this order: 6-bit [31:26], 8-bit [31:24], 9-bit [31:23], 10-bit [31:22], 11-bit [31:21].
  - B: 000101 (B), 100101 (BL). imm = sext(instr[25:0]) << BR_SHIFT.
  - CB: 10110100 (CBZ), 10110101 (CBNZ), 01010100 (B.cond). imm = sext(instr[23:5]) << BR_SHIFT.
  - IW: 110100101 (MOVZ), 111100101 (MOVK). imm = zext(instr[20:5]) << (16*instr[22:21]).
  - I: 1001000100 (ADDI), 1101000100 (SUBI), 1001001000 (ANDI), 1011001000 (ORRI). imm = zext(instr[21:10]).
  - D: 11111000010 (LDUR), 11111000000 (STUR). imm = sext(instr[20:12]).
  - R: 10001011000, 11001011000, 10001010000, 10101010000, 11010011011, 11010011010, 11010110000. imm = 0.
  - No match: fmt=R, imm=0, out_illegal=1. The instruction still flows through the handshake.
- Shifts are performed after extension, in DATA_W. Bits shifted past DATA_W-1 are discarded.

Decomposition:
- Shared package imm_decode_pkg holds:
  - format code constants FMT_R..FMT_IW;
  - opcode constants for every entry above;
  - field bit positions.
- Sub-module imm_field_decode (combinational) takes instr and returns fmt, illegal and imm.
  - It instantiates SignExtender three times: NUM_IN_BITS 9/19/26, NUM_OUT_BITS DATA_W.
- The top level owns only the register slice and the handshake.

Test Plan:
- in_instr=0xF85F8041 (LDUR X1,[X2,#-8]) with out_ready=1 -> one cycle later out_valid=1, fmt=2, out_imm=0xFFFFFFFFFFFFFFF8, out_illegal=0.
- 0x17FFFFFC (B -4), then 0xB4000020 (CBZ +1), back-to-back -> out_imm=0xFFFFFFFFFFFFFFF0 fmt=3, then 0x0000000000000004 fmt=4, on consecutive cycles.
- 0x913FFC00 (ADDI #4095) -> out_imm=0x0000000000000FFF, fmt=1. 0xD2C24680 (MOVZ #0x1234,LSL 32) -> out_imm=0x0000123400000000, fmt=5.
- 0x00000000 -> out_illegal=1, out_imm=0, fmt=0, out_valid=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 and new instructions presented -> in_ready=0 and outputs unchanged. Then out_ready=1 -> next instruction appears one cycle later.
- Flush in a stall cycle and in a load cycle -> out_valid=0 next edge in both cases, and the loaded instruction is never presented. Reset asserted while out_valid=1 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared constants for the LEGv8 decode-stage immediate slice:
// format codes, opcode patterns and immediate field positions.
package imm_decode_pkg;

    // Format codes presented on out_fmt
    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_CB = 3'd4;
    localparam logic [2:0] FMT_IW = 3'd5;

    // B format, 6-bit opcode [31:26]
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    // CB format, 8-bit opcode [31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCND = 8'b01010100;
    // IW format, 9-bit opcode [31:23]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [8:0]  OP_MOVK = 9'b111100101;
    // I format, 10-bit opcode [31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    // D format, 11-bit opcode [31:21]
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // R format, 11-bit opcode [31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    // Immediate field positions
    localparam int B_IMM_HI  = 25;
    localparam int B_IMM_LO  = 0;
    localparam int CB_IMM_HI = 23;
    localparam int CB_IMM_LO = 5;
    localparam int IW_IMM_HI = 20;
    localparam int IW_IMM_LO = 5;
    localparam int IW_HW_HI  = 22;
    localparam int IW_HW_LO  = 21;
    localparam int I_IMM_HI  = 21;
    localparam int I_IMM_LO  = 10;
    localparam int D_IMM_HI  = 20;
    localparam int D_IMM_LO  = 12;

endpackage

// File: rtl/SignExtender.sv
// Replicates the top bit of an N-bit field out to the full output width.
module SignExtender #(
    parameter int NUM_IN_BITS  = 9,
    parameter int NUM_OUT_BITS = 64
) (
    input  logic [NUM_IN_BITS-1:0]  din,
    output logic [NUM_OUT_BITS-1:0] dout
);
    assign dout = {{(NUM_OUT_BITS-NUM_IN_BITS){din[NUM_IN_BITS-1]}}, din};
endmodule

// File: rtl/imm_decode_field_decode.sv
// Combinational classifier: matches the opcode (shortest first) and builds
// the DATA_W immediate for the matched format.
module imm_field_decode
    import imm_decode_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int INSTR_W  = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [2:0]         fmt,
    output logic               illegal,
    output logic [DATA_W-1:0]  imm
);
    logic [DATA_W-1:0] sext_d, sext_cb, sext_b;
    logic [DATA_W-1:0] zext_iw, zext_i;
    logic [5:0]        iw_shamt;
    logic [5:0]        op6;
    logic [7:0]        op8;
    logic [8:0]        op9;
    logic [9:0]        op10;
    logic [10:0]       op11;
    logic              unused_low_bits;

    // Rd/Rt field carries no immediate information
    assign unused_low_bits = ^instr[4:0];

    assign op6  = instr[31:26];
    assign op8  = instr[31:24];
    assign op9  = instr[31:23];
    assign op10 = instr[31:22];
    assign op11 = instr[31:21];

    SignExtender #(.NUM_IN_BITS(9),  .NUM_OUT_BITS(DATA_W)) u_sext_d (
        .din(instr[D_IMM_HI:D_IMM_LO]), .dout(sext_d));
    SignExtender #(.NUM_IN_BITS(19), .NUM_OUT_BITS(DATA_W)) u_sext_cb (
        .din(instr[CB_IMM_HI:CB_IMM_LO]), .dout(sext_cb));
    SignExtender #(.NUM_IN_BITS(26), .NUM_OUT_BITS(DATA_W)) u_sext_b (
        .din(instr[B_IMM_HI:B_IMM_LO]), .dout(sext_b));

    assign zext_iw  = DATA_W'(instr[IW_IMM_HI:IW_IMM_LO]);
    assign zext_i   = DATA_W'(instr[I_IMM_HI:I_IMM_LO]);
    // hw field selects a 16-bit lane: shift by 0/16/32/48
    assign iw_shamt = {instr[IW_HW_HI:IW_HW_LO], 4'b0000};

    // First-hit opcode match, narrowest opcode field first
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        imm     = '0;
        if (op6 == OP_B || op6 == OP_BL) begin
            fmt = FMT_B;
            imm = sext_b << BR_SHIFT;
        end else if (op8 == OP_CBZ || op8 == OP_CBNZ || op8 == OP_BCND) begin
            fmt = FMT_CB;
            imm = sext_cb << BR_SHIFT;
        end else if (op9 == OP_MOVZ || op9 == OP_MOVK) begin
            fmt = FMT_IW;
            imm = zext_iw << iw_shamt;
        end else if (op10 == OP_ADDI || op10 == OP_SUBI ||
                     op10 == OP_ANDI || op10 == OP_ORRI) begin
            fmt = FMT_I;
            imm = zext_i;
        end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
            fmt = FMT_D;
            imm = sext_d;
        end else if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND ||
                     op11 == OP_ORR || op11 == OP_LSL || op11 == OP_LSR ||
                     op11 == OP_BR) begin
            fmt = FMT_R;
            imm = '0;
        end else begin
            illegal = 1'b1;
        end
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage register slice: one-entry valid/ready pipe holding the PC,
// format and extended immediate of the captured instruction.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int INSTR_W  = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pc,
    output logic [DATA_W-1:0]  out_imm,
    output logic [2:0]         out_fmt,
    output logic               out_illegal
);
    logic [2:0]        dec_fmt;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_imm;
    logic              load;

    imm_field_decode #(
        .DATA_W(DATA_W), .INSTR_W(INSTR_W), .BR_SHIFT(BR_SHIFT)
    ) u_dec (
        .instr(in_instr), .fmt(dec_fmt), .illegal(dec_illegal), .imm(dec_imm)
    );

    // No skid buffer: accept only when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Slice register: reset > flush > load > drain; otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_fmt     <= FMT_R;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage with hand-computed expectations.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    imm_decode_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".imm"},   out_imm, imm);
        chk({tag, ".fmt"},   64'(out_fmt), 64'(fmt));
        chk({tag, ".ill"},   64'(out_illegal), 64'(ill));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        expect_out("rst", 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // LDUR X1,[X2,#-8]
        in_valid = 1'b1; in_instr = 32'hF85F8041; in_pc = 64'h1000;
        tick();
        expect_out("ldur", 1'b1, 64'h1000, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);

        // B -4 then CBZ +1 back-to-back
        in_instr = 32'h17FFFFFC; in_pc = 64'h1004;
        tick();
        expect_out("b", 1'b1, 64'h1004, 64'hFFFFFFFFFFFFFFF0, 3'd3, 1'b0);
        in_instr = 32'hB4000020; in_pc = 64'h1008;
        tick();
        expect_out("cbz", 1'b1, 64'h1008, 64'h4, 3'd4, 1'b0);

        // ADDI #4095, MOVZ #0x1234 LSL 32
        in_instr = 32'h913FFC00; in_pc = 64'h100C;
        tick();
        expect_out("addi", 1'b1, 64'h100C, 64'hFFF, 3'd1, 1'b0);
        in_instr = 32'hD2C24680; in_pc = 64'h1010;
        tick();
        expect_out("movz", 1'b1, 64'h1010, 64'h0000123400000000, 3'd5, 1'b0);

        // Unmatched opcode still flows
        in_instr = 32'h00000000; in_pc = 64'h1014;
        tick();
        expect_out("illeg", 1'b1, 64'h1014, 64'h0, 3'd0, 1'b1);

        // ADD (R format) loaded, then stall 3 cycles while new instrs offered
        in_instr = 32'h8B020020; in_pc = 64'h2000;
        tick();
        expect_out("add", 1'b1, 64'h2000, 64'h0, 3'd0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_instr = (i == 0) ? 32'h913FFC00 : 32'hF85F8041;
            in_pc    = 64'h3000 + 64'(i);
            #1;
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            tick();
            expect_out("stall", 1'b1, 64'h2000, 64'h0, 3'd0, 1'b0);
        end
        // release: LDUR offered now appears one cycle later
        out_ready = 1'b1;
        in_instr = 32'hF85F8041; in_pc = 64'h3002;
        #1;
        chk("release.in_ready", 64'(in_ready), 64'd1);
        tick();
        expect_out("release", 1'b1, 64'h3002, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);

        // Drain: no input, valid drops, data kept
        in_valid = 1'b0;
        tick();
        expect_out("drain", 1'b0, 64'h3002, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);

        // Flush during stall
        in_valid = 1'b1; in_instr = 32'hD2C24680; in_pc = 64'h4000;
        tick();
        expect_out("movz2", 1'b1, 64'h4000, 64'h0000123400000000, 3'd5, 1'b0);
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        expect_out("flush.stall", 1'b0, 64'h4000, 64'h0000123400000000, 3'd5, 1'b0);

        // Flush during a load cycle: the offered B is dropped
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h17FFFFFC; in_pc = 64'h5000;
        tick();
        expect_out("flush.load", 1'b0, 64'h4000, 64'h0000123400000000, 3'd5, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        expect_out("flush.gone", 1'b0, 64'h4000, 64'h0000123400000000, 3'd5, 1'b0);

        // Reset while valid beats a concurrent load
        in_valid = 1'b1; in_instr = 32'hB4000020; in_pc = 64'h6000;
        tick();
        expect_out("cbz2", 1'b1, 64'h6000, 64'h4, 3'd4, 1'b0);
        reset = 1'b1; in_instr = 32'h00000000;
        tick();
        expect_out("rst2", 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        reset = 1'b0; in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
